mmcm_ps_sequencer: RTL and testbench
====================================

MMCM_PS_SEQUENCER -- requirements
Module: mmcm_ps_sequencer

Interface
REQ-001 SHALL have one clock, psclk; reset is asynchronous and active-low, reset_n.
REQ-002 Parameters SHALL be:
- STEP_W, 16, width of signed step request.
- POS_W, 32, width of signed phase position.
- TIMEOUT_CYC, 1023, psclk cycles allowed between psen and psdone.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- psclk  in  1  MMCM phase-shift clock; all logic on rising edge.
- reset_n  in  1  async active-low reset.
- req_valid  in  1  step request valid.
- req_ready  out  1  sequencer accepts a request.
- req_steps  in  STEP_W  signed step count; positive = increment, negative = decrement.
- spacing  in  16  minimum idle cycles between psdone and the next psen; sampled at accept.
- abort  in  1  level; stop at the next safe point.
- mmcm_locked  in  1  MMCM locked status, already in psclk domain.
- psen  out  1  MMCM phase-shift enable.
- psincdec  out  1  MMCM direction; 1 = increment.
- psdone  in  1  MMCM step complete.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse at request end (normal, abort or timeout).
- timeout_err  out  1  sticky psdone-timeout flag.
- phase_pos  out  POS_W  signed net steps completed since reset.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT_DONE and GAP, with registered outputs.
REQ-005 req_ready SHALL be 1 only in IDLE with mmcm_locked=1; a request is accepted on req_valid & req_ready.
REQ-006 On accept with req_steps=0: done SHALL pulse next cycle, no psen issued, FSM stays IDLE.
REQ-007 On accept with req_steps≠0:
- latch remaining = |req_steps| as unsigned STEP_W (-2^(STEP_W-1) gives 2^(STEP_W-1)).
- latch dir = ~sign, and the spacing value.
- go to ISSUE; busy=1 from the next cycle.
REQ-008 ISSUE SHALL assert psen for exactly one cycle (first psen one cycle after accept), then go to WAIT_DONE.
REQ-009 psincdec SHALL equal dir from ISSUE entry until request end, and hold its last value otherwise.
REQ-010 WAIT_DONE on psdone:
- remaining decrements; phase_pos increments (dir=1) or decrements (dir=0), wrapping two's complement.
- if remaining reaches 0: done pulses, go to IDLE.
- else go to GAP with the gap counter loaded with spacing.
REQ-011 GAP SHALL count down and enter ISSUE when the counter is 0; spacing=0 means ISSUE on the cycle after psdone.
REQ-012 psdone outside WAIT_DONE SHALL be ignored: no count, no position change.
REQ-013 abort or mmcm_locked=0 SHALL end the request:
- in ISSUE or GAP: immediately (done pulse, go to IDLE, psen deasserted).
- in WAIT_DONE: only after psdone, counting that step.
REQ-014 A psdone coinciding with abort in WAIT_DONE SHALL count the step and end the request in the same cycle.
REQ-015 busy SHALL fall in the same cycle done pulses.

Reset
REQ-016 Reset SHALL asynchronously force IDLE and psen=0, psincdec=0, busy=0, done=0, timeout_err=0, phase_pos=0, req_ready=0.
REQ-017 Reset mid-request SHALL discard the request with no done pulse.

Configuration
REQ-018 With MMCM_PS_TIMEOUT_EN defined, a WAIT_DONE watchdog SHALL be compiled in. If TIMEOUT_CYC cycles pass without psdone:
- set timeout_err.
- pulse done, go to IDLE; phase_pos unchanged.
- timeout_err clears on the next accept.
REQ-019 Without MMCM_PS_TIMEOUT_EN, timeout_err SHALL be tied 0 and WAIT_DONE waits indefinitely.

Structure
REQ-020 A shared package mmcm_ps_pkg SHALL hold the state enum, the default STEP_W/POS_W/TIMEOUT_CYC constants and the direction encoding constants.
REQ-021 One sub-module, mmcm_ps_gap_timer (loadable down-counter with zero flag, reused for the GAP and timeout counts), SHALL be used; the rest is flat.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- req_steps=+3, spacing=2, psdone 5 cycles after each psen → 3 psen pulses with psincdec=1, ≥2 idle cycles between each psdone and the next psen, one done pulse, phase_pos=+3.
- req_steps=-2, spacing=0 → psincdec=0, next psen one cycle after each psdone, phase_pos=+1 (after scenario 1).
- req_steps=0 → done next cycle, zero psen, busy stays 0.
- req_steps=+10, abort in WAIT_DONE of step 4 → step 4 completes, no 5th psen, done pulses, phase_pos increases by 4.
- MMCM_PS_TIMEOUT_EN defined, TIMEOUT_CYC=16, psdone withheld → done pulses and timeout_err=1 after 16 cycles; next accept clears timeout_err.
- reset_n low during GAP → psen=0, busy=0, phase_pos=0, no done pulse; req_ready=1 after reset release with mmcm_locked=1.

Source files
------------

// File: rtl/mmcm_ps_pkg.sv
// Shared types and constants for the MMCM phase-shift sequencer.
package mmcm_ps_pkg;

  localparam int STEP_W_DEF      = 16;
  localparam int POS_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 1023;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP
  } ps_state_t;

endpackage

// File: rtl/mmcm_ps_sequencer_if.sv
// Step-request handshake: valid/ready with signed step count and inter-step spacing.
interface mmcm_ps_sequencer_if #(
  parameter int STEP_W = 16
);
  logic                     req_valid;
  logic                     req_ready;
  logic signed [STEP_W-1:0] req_steps;
  logic [15:0]              spacing;

  modport master (output req_valid, req_steps, spacing, input req_ready);
  modport slave  (input req_valid, req_steps, spacing, output req_ready);
endinterface

// File: rtl/mmcm_ps_gap_timer.sv
// Loadable down-counter with zero flag, shared by the GAP spacing and psdone watchdog counts.
// Load wins over decrement; the count holds at zero.
module mmcm_ps_gap_timer #(
  parameter int W = 16
) (
  input  logic         psclk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge psclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mmcm_ps_sequencer.sv
// MMCM fine phase-shift sequencer: first psen one cycle after accept, req_ready low while busy or unlocked.
// Optional psdone watchdog compiled in with `define MMCM_PS_TIMEOUT_EN.
module mmcm_ps_sequencer
  import mmcm_ps_pkg::*;
#(
  parameter int STEP_W      = STEP_W_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    psclk,
  input  logic                    reset_n,
  mmcm_ps_sequencer_if.slave      req_if,
  input  logic                    abort,
  input  logic                    mmcm_locked,
  input  logic                    psdone,
  output logic                    psen,
  output logic                    psincdec,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic signed [POS_W-1:0] phase_pos
);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int TMR_W = (TO_W > 16) ? TO_W : 16;

  ps_state_t               state, state_n;
  logic [STEP_W-1:0]       remaining, remaining_n, steps_mag;
  logic                    dir, dir_n;
  logic [15:0]             spacing_q, spacing_n;
  logic                    psen_n, psincdec_n, done_n, rdy_q;
  logic signed [POS_W-1:0] pos_n;
  logic                    tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]        tmr_val;
  logic                    accept, stop, step_sign;
`ifdef MMCM_PS_TIMEOUT_EN
  logic                    terr_q, terr_n;
`endif

  assign step_sign      = req_if.req_steps[STEP_W-1];
  // Most negative step count maps to 2^(STEP_W-1) as an unsigned magnitude.
  assign steps_mag      = step_sign ? (~req_if.req_steps + STEP_W'(1)) : req_if.req_steps;
  assign accept         = req_if.req_valid & rdy_q;
  assign stop           = abort | ~mmcm_locked;
  assign req_if.req_ready = rdy_q;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dir_n       = dir;
    spacing_n   = spacing_q;
    pos_n       = phase_pos;
    psincdec_n  = psincdec;
    psen_n      = 1'b0;
    done_n      = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_val     = '0;
`ifdef MMCM_PS_TIMEOUT_EN
    terr_n      = terr_q;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef MMCM_PS_TIMEOUT_EN
          terr_n = 1'b0;
`endif
          if (steps_mag == '0) begin
            done_n = 1'b1;
          end else begin
            remaining_n = steps_mag;
            dir_n       = step_sign ? DIR_DEC : DIR_INC;
            psincdec_n  = dir_n;
            spacing_n   = req_if.spacing;
            psen_n      = 1'b1;
            state_n     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (stop) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT_DONE;
`ifdef MMCM_PS_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
`endif
        end
      end
      ST_WAIT_DONE: begin
        if (psdone) begin
          remaining_n = remaining - STEP_W'(1);
          pos_n = (dir == DIR_INC) ? phase_pos + POS_W'(1) : phase_pos - POS_W'(1);
          if ((remaining_n == '0) || stop) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else if (spacing_q == '0) begin
            psen_n  = 1'b1;
            state_n = ST_ISSUE;
          end else begin
            // GAP occupies exactly spacing idle cycles before the next psen.
            state_n  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(spacing_q - 16'd1);
          end
        end
`ifdef MMCM_PS_TIMEOUT_EN
        else if (tmr_zero) begin
          terr_n  = 1'b1;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (stop) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (tmr_zero) begin
          psen_n  = 1'b1;
          state_n = ST_ISSUE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge psclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir       <= DIR_DEC;
      spacing_q <= '0;
      psen      <= 1'b0;
      psincdec  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdy_q     <= 1'b0;
      phase_pos <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dir       <= dir_n;
      spacing_q <= spacing_n;
      psen      <= psen_n;
      psincdec  <= psincdec_n;
      busy      <= (state_n != ST_IDLE);
      done      <= done_n;
      rdy_q     <= (state_n == ST_IDLE) & mmcm_locked;
      phase_pos <= pos_n;
    end
  end

`ifdef MMCM_PS_TIMEOUT_EN
  always_ff @(posedge psclk or negedge reset_n) begin
    if (!reset_n) begin
      terr_q <= 1'b0;
    end else begin
      terr_q <= terr_n;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  mmcm_ps_gap_timer #(
    .W (TMR_W)
  ) u_gap_timer (
    .psclk    (psclk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );
endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// Directed bench for mmcm_ps_sequencer with a behavioural MMCM psdone responder.
module tb_mmcm_ps_sequencer;
`ifdef MMCM_PS_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1023;
`endif

  logic        psclk;
  logic        reset_n;
  logic        abort;
  logic        mmcm_locked;
  logic        psdone = 1'b0;
  logic        psen, psincdec, busy, done, timeout_err;
  logic signed [31:0] phase_pos;

  mmcm_ps_sequencer_if #(.STEP_W(16)) req_if ();

  mmcm_ps_sequencer #(
    .STEP_W      (16),
    .POS_W       (32),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .psclk       (psclk),
    .reset_n     (reset_n),
    .req_if      (req_if),
    .abort       (abort),
    .mmcm_locked (mmcm_locked),
    .psdone      (psdone),
    .psen        (psen),
    .psincdec    (psincdec),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .phase_pos   (phase_pos)
  );

  initial psclk = 1'b0;
  always #5 psclk = ~psclk;

  // Stimulus-owned knobs read by the MMCM model
  int   dly       = 5;
  bit   mmcm_hold = 1'b0;
  bit   inject    = 1'b0;
  logic exp_dir   = 1'b0;

  // Monitor-owned state: cumulative counts, gaps summarised per request at its done pulse
  int cyc = 0, cd = -1, psen_cnt = 0, done_cnt = 0, busy_cnt = 0, dir_err_cnt = 0;
  int last_done_cyc = 0, gap = 0, cur_min = 1000, cur_max = -1, req_min = 1000, req_max = -1;
  bit gap_armed = 1'b0;

  always @(negedge psclk) begin
    cyc++;
    psdone = inject;
    if (cd == 0) begin
      psdone = 1'b1;
      cd = -1;
    end else if (cd > 0) begin
      cd--;
    end
    if (psdone && busy) begin
      gap_armed = 1'b1;
      last_done_cyc = cyc;
    end
    if (psen) begin
      psen_cnt++;
      if (psincdec !== exp_dir) dir_err_cnt++;
      if (gap_armed) begin
        gap = cyc - last_done_cyc - 1;
        if (gap < cur_min) cur_min = gap;
        if (gap > cur_max) cur_max = gap;
      end
      gap_armed = 1'b0;
      if (!mmcm_hold) cd = dly - 1;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      req_min = cur_min;
      req_max = cur_max;
      cur_min = 1000;
      cur_max = -1;
      gap_armed = 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] s, input logic [15:0] sp,
                      output logic first_psen, output logic first_done);
    int i = 0;
    while (req_if.req_ready !== 1'b1 && i < 100) begin
      @(negedge psclk);
      i++;
    end
    chk("req_ready before send", req_if.req_ready, 1);
    req_if.req_valid = 1'b1;
    req_if.req_steps = s;
    req_if.spacing   = sp;
    @(negedge psclk);
    req_if.req_valid = 1'b0;
    first_psen = psen;
    first_done = done;
  endtask

  task automatic wait_done(input int limit, output int n, output logic b);
    n = 0;
    b = 1'bx;
    while (n < limit) begin
      @(negedge psclk);
      n++;
      if (done === 1'b1) begin
        b = busy;
        return;
      end
    end
    n = -1;
  endtask

  task automatic pulse_psdone();
    @(posedge psclk);
    #2 inject = 1'b1;
    @(posedge psclk);
    #2 inject = 1'b0;
  endtask

  typedef struct {
    logic signed [15:0] steps;
    logic [15:0]        spc;
    int                 dly;
    int                 exp_psen;
    int                 exp_pos;
    logic               exp_dir;
    int                 exp_gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic fp, fd, b;
    int   n, i, p0, d0, b0, e0, exp_pos;

    // steps, spacing, psdone delay, psen count, absolute phase_pos, final psincdec, gap (-1 = none)
    vecs[0] = '{16'sd3,  16'd2, 5, 3,  3, 1'b1,  2};
    vecs[1] = '{-16'sd2, 16'd0, 5, 2,  1, 1'b0,  0};
    vecs[2] = '{16'sd0,  16'd0, 5, 0,  1, 1'b0, -1};
    vecs[3] = '{16'sd1,  16'd3, 2, 1,  2, 1'b1, -1};
    vecs[4] = '{-16'sd3, 16'd1, 1, 3, -1, 1'b0,  1};

    reset_n = 1'b1;
    abort = 1'b0;
    mmcm_locked = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_steps = '0;
    req_if.spacing = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("reset psen", psen, 0);
    chk("reset psincdec", psincdec, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset phase_pos", phase_pos, 0);
    chk("reset req_ready", req_if.req_ready, 0);
    repeat (2) @(negedge psclk);
    reset_n = 1'b1;
    repeat (2) @(negedge psclk);
    chk("req_ready after reset", req_if.req_ready, 1);

    for (int k = 0; k < 5; k++) begin
      dly = vecs[k].dly;
      exp_dir = vecs[k].exp_dir;
      p0 = psen_cnt; d0 = done_cnt; b0 = busy_cnt; e0 = dir_err_cnt;
      send(vecs[k].steps, vecs[k].spc, fp, fd);
      if (vecs[k].steps == 0) begin
        chk($sformatf("v%0d done next cycle", k), fd, 1);
      end else begin
        chk($sformatf("v%0d first psen", k), fp, 1);
        wait_done(500, n, b);
        chk($sformatf("v%0d done seen", k), n > 0, 1);
        chk($sformatf("v%0d busy at done", k), b, 0);
      end
      repeat (4) @(negedge psclk);
      chk($sformatf("v%0d psen count", k), psen_cnt - p0, vecs[k].exp_psen);
      chk($sformatf("v%0d done count", k), done_cnt - d0, 1);
      chk($sformatf("v%0d phase_pos", k), phase_pos, vecs[k].exp_pos);
      chk($sformatf("v%0d psincdec", k), psincdec, vecs[k].exp_dir);
      chk($sformatf("v%0d psincdec at psen", k), dir_err_cnt - e0, 0);
      chk($sformatf("v%0d busy seen", k), (busy_cnt - b0) > 0, vecs[k].steps != 0);
      if (vecs[k].exp_gap >= 0) begin
        chk($sformatf("v%0d min gap", k), req_min, vecs[k].exp_gap);
        chk($sformatf("v%0d max gap", k), req_max, vecs[k].exp_gap);
      end
    end
    exp_pos = -1;

    // psdone while idle must not move the position
    d0 = done_cnt;
    pulse_psdone();
    repeat (3) @(negedge psclk);
    chk("idle psdone phase_pos", phase_pos, exp_pos);
    chk("idle psdone no done", done_cnt - d0, 0);

    // abort during WAIT_DONE of step 4: that step completes, no fifth psen
    dly = 3; exp_dir = 1'b1;
    p0 = psen_cnt; d0 = done_cnt;
    send(16'sd10, 16'd1, fp, fd);
    i = 0;
    while ((psen_cnt - p0) < 4 && i < 500) begin
      @(negedge psclk);
      i++;
    end
    chk("abort psen 4 reached", (psen_cnt - p0) >= 4, 1);
    @(negedge psclk);
    abort = 1'b1;
    wait_done(50, n, b);
    abort = 1'b0;
    chk("abort done seen", n > 0, 1);
    repeat (8) @(negedge psclk);
    exp_pos += 4;
    chk("abort psen count", psen_cnt - p0, 4);
    chk("abort phase_pos", phase_pos, exp_pos);
    chk("abort done count", done_cnt - d0, 1);

    // psdone withheld
    mmcm_hold = 1'b1;
    d0 = done_cnt;
    send(16'sd1, 16'd0, fp, fd);
`ifdef MMCM_PS_TIMEOUT_EN
    wait_done(100, n, b);
    // done follows TO_CYC full WAIT_DONE cycles without psdone
    chk("timeout done latency", n, TO_CYC + 1);
    chk("timeout_err set", timeout_err, 1);
    repeat (3) @(negedge psclk);
    chk("timeout phase_pos", phase_pos, exp_pos);
    chk("timeout done count", done_cnt - d0, 1);
    mmcm_hold = 1'b0;
    send(16'sd0, 16'd0, fp, fd);
    chk("timeout_err cleared on accept", timeout_err, 0);
`else
    repeat (40) @(negedge psclk);
    chk("no watchdog busy", busy, 1);
    chk("no watchdog timeout_err", timeout_err, 0);
    chk("no watchdog done count", done_cnt - d0, 0);
    mmcm_hold = 1'b0;
    pulse_psdone();
    wait_done(10, n, b);
    chk("late psdone done seen", n > 0, 1);
    repeat (3) @(negedge psclk);
    exp_pos += 1;
    chk("late psdone phase_pos", phase_pos, exp_pos);
`endif

    // reset while in GAP discards the request silently
    repeat (3) @(negedge psclk);
    dly = 1; exp_dir = 1'b1;
    p0 = psen_cnt; d0 = done_cnt;
    send(16'sd5, 16'd20, fp, fd);
    repeat (5) @(negedge psclk);
    chk("gap busy before reset", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("gap reset psen", psen, 0);
    chk("gap reset busy", busy, 0);
    chk("gap reset phase_pos", phase_pos, 0);
    chk("gap reset req_ready", req_if.req_ready, 0);
    repeat (2) @(negedge psclk);
    reset_n = 1'b1;
    repeat (3) @(negedge psclk);
    chk("gap reset req_ready after", req_if.req_ready, 1);
    chk("gap reset no done", done_cnt - d0, 0);
    chk("gap reset one psen", psen_cnt - p0, 1);
    chk("gap reset busy after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
